// File: rtl/v_status_sticky_reg_pkg.sv
// rtl/v_status_sticky_reg_pkg.sv - shared state encoding and default sizes for the sticky status register
package v_status_sticky_reg_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RESP = 2'd1,
    HOLD = 2'd2
  } state_e;

  localparam int WIDTH_DEF = 8;
  localparam int CNT_W_DEF = 4;

endpackage

// File: rtl/v_sat_counter.sv
// rtl/v_sat_counter.sv - saturating up-counter with synchronous clear and increment enable
// Clear takes priority over increment; the count sticks at all-ones.
module v_sat_counter
  import v_status_sticky_reg_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             C,
  input  logic             CLR,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge C or negedge CLR) begin
    if (!CLR) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/v_status_sticky_reg.sv
// rtl/v_status_sticky_reg.sv - sticky event status with clear-on-read reader port and masked IRQ
// Define STICKY_EDGE_EN to make events rising-edge qualified instead of level.
module v_status_sticky_reg
  import v_status_sticky_reg_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             C,
  input  logic             CLR,
  input  logic [WIDTH-1:0] EV,
  input  logic             MASK_WE,
  input  logic [WIDTH-1:0] MASK_D,
  input  logic             RD_REQ,
  output logic             RD_VLD,
  output logic [WIDTH-1:0] RD_DATA,
  output logic [CNT_W-1:0] RD_OVF,
  output logic             IRQ
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] status_q, status_d;
  logic [WIDTH-1:0] mask_q;
  logic [WIDTH-1:0] rd_data_q;
  logic [CNT_W-1:0] rd_ovf_q;
  logic [CNT_W-1:0] ovf_cnt;
  logic [WIDTH-1:0] ev_set;
  logic             irq_q;
  logic             capture;
  logic             ovf_hit;

`ifdef STICKY_EDGE_EN
  logic [WIDTH-1:0] ev_q;

  always_ff @(posedge C or negedge CLR) begin
    if (!CLR) begin
      ev_q <= '0;
    end else begin
      ev_q <= EV;
    end
  end

  assign ev_set = EV & ~ev_q;
`else
  assign ev_set = EV;
`endif

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (RD_REQ) begin
          state_d = RESP;
          capture = 1'b1;
        end
      end
      RESP:    state_d = RD_REQ ? HOLD : IDLE;
      HOLD:    if (!RD_REQ) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Set wins over the clear-on-read so events landing on the capture edge survive.
  assign status_d = capture ? ev_set : (status_q | ev_set);
  assign ovf_hit  = ~capture & (|(ev_set & status_q));

  v_sat_counter #(
    .CNT_W(CNT_W)
  ) u_ovf_cnt (
    .C    (C),
    .CLR  (CLR),
    .clr_i(capture),
    .inc_i(ovf_hit),
    .cnt_o(ovf_cnt)
  );

  always_ff @(posedge C or negedge CLR) begin
    if (!CLR) begin
      state_q   <= IDLE;
      status_q  <= '0;
      mask_q    <= '0;
      rd_data_q <= '0;
      rd_ovf_q  <= '0;
      irq_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
      irq_q    <= |(status_q & mask_q);
      if (MASK_WE) begin
        mask_q <= MASK_D;
      end
      if (capture) begin
        rd_data_q <= status_q;
        rd_ovf_q  <= ovf_cnt;
      end
    end
  end

  assign RD_VLD  = (state_q == RESP);
  assign RD_DATA = rd_data_q;
  assign RD_OVF  = rd_ovf_q;
  assign IRQ     = irq_q;

endmodule

// File: tb/tb_v_status_sticky_reg.sv
// tb/tb_v_status_sticky_reg.sv - directed and randomized checks of v_status_sticky_reg against a behavioural model
module tb_v_status_sticky_reg;

  localparam int W  = 8;
  localparam int CW = 4;

  logic          C = 1'b0;
  logic          CLR = 1'b0;
  logic [W-1:0]  EV = '0;
  logic          MASK_WE = 1'b0;
  logic [W-1:0]  MASK_D = '0;
  logic          RD_REQ = 1'b0;
  logic          RD_VLD;
  logic [W-1:0]  RD_DATA;
  logic [CW-1:0] RD_OVF;
  logic          IRQ;

  int total = 0;
  int bad   = 0;

  always #5 C = ~C;

  v_status_sticky_reg #(.WIDTH(W), .CNT_W(CW)) dut (
    .C      (C),
    .CLR    (CLR),
    .EV     (EV),
    .MASK_WE(MASK_WE),
    .MASK_D (MASK_D),
    .RD_REQ (RD_REQ),
    .RD_VLD (RD_VLD),
    .RD_DATA(RD_DATA),
    .RD_OVF (RD_OVF),
    .IRQ    (IRQ)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a read is served once per request assertion; "served" tracks that.
  logic [W-1:0]  m_status, m_mask, m_rd_data, m_ev_prev;
  int            m_ovf;
  logic [CW-1:0] m_rd_ovf;
  logic          m_irq, m_vld, m_served;

  always @(posedge C or negedge CLR) begin
    logic [W-1:0] set;
    logic         cap, irq_n;
    if (!CLR) begin
      m_status = '0; m_mask = '0; m_rd_data = '0; m_ev_prev = '0;
      m_ovf = 0; m_rd_ovf = '0; m_irq = 0; m_vld = 0; m_served = 0;
    end else begin
`ifdef STICKY_EDGE_EN
      set = EV & ~m_ev_prev;
`else
      set = EV;
`endif
      cap   = RD_REQ && !m_served;
      irq_n = (m_status & m_mask) != 0;
      if (cap) begin
        m_rd_data = m_status;
        m_rd_ovf  = CW'(m_ovf);
        m_status  = set;
        m_ovf     = 0;
      end else begin
        if ((set & m_status) != 0 && m_ovf < (2 ** CW) - 1) m_ovf = m_ovf + 1;
        m_status = m_status | set;
      end
      if (MASK_WE) m_mask = MASK_D;
      m_vld     = cap;
      m_served  = RD_REQ;
      m_irq     = irq_n;
      m_ev_prev = EV;
    end
  end

  always @(negedge C) begin
    if (CLR) begin
      check("rd_vld", RD_VLD, m_vld);
      check("rd_data", RD_DATA, m_rd_data);
      check("rd_ovf", RD_OVF, m_rd_ovf);
      check("irq", IRQ, m_irq);
    end
  end

  task automatic read_hold(input int hold, input logic [W-1:0] ev_cap, input logic [W-1:0] ev_after,
                           output logic [W-1:0] d, output logic [CW-1:0] o, output int pulses);
    pulses = 0;
    d = 'x;
    o = 'x;
    EV = ev_cap;
    RD_REQ = 1'b1;
    for (int i = 0; i < hold + 2; i++) begin
      @(negedge C);
      if (i == 0) EV = ev_after;
      if (i == hold - 1) RD_REQ = 1'b0;
      if (RD_VLD) begin
        pulses++;
        d = RD_DATA;
        o = RD_OVF;
      end
    end
  endtask

  logic [W-1:0]  d;
  logic [CW-1:0] o;
  int            p;

  initial begin
    // 1: reset ignores events, first read and clear
    CLR = 1'b0;
    EV  = 8'hFF;
    repeat (3) @(negedge C);
    check("rst_vld", RD_VLD, 0);
    check("rst_irq", IRQ, 0);
    check("rst_data", RD_DATA, 0);
    EV  = 8'h00;
    CLR = 1'b1;
    @(negedge C);
    EV = 8'h05;
    @(negedge C);
    EV = 8'h00;
    read_hold(3, 8'h00, 8'h00, d, o, p);
    check("t1_pulses", p, 1);
    check("t1_data", d, 8'h05);
    check("t1_ovf", o, 0);
    read_hold(1, 8'h00, 8'h00, d, o, p);
    check("t1_data2", d, 8'h00);

    // 2: set beats clear on the capture edge
    EV = 8'h01;
    @(negedge C);
    read_hold(2, 8'h02, 8'h00, d, o, p);
    check("t2_data", d, 8'h01);
    read_hold(1, 8'h00, 8'h00, d, o, p);
    check("t2_data2", d, 8'h02);

`ifndef STICKY_EDGE_EN
    // 3: overflow saturates at 15
    EV = 8'h08;
    repeat (20) @(negedge C);
    EV = 8'h00;
    read_hold(1, 8'h00, 8'h00, d, o, p);
    check("t3_ovf", o, 15);
    check("t3_data", d, 8'h08);
    read_hold(1, 8'h00, 8'h00, d, o, p);
    check("t3_ovf2", o, 0);
`endif

    // 4: IRQ timing through mask and read
    MASK_WE = 1'b1;
    MASK_D  = 8'h10;
    @(negedge C);
    MASK_WE = 1'b0;
    EV = 8'h10;
    @(negedge C);
    EV = 8'h00;
    check("t4_irq_lag", IRQ, 0);
    @(negedge C);
    check("t4_irq_set", IRQ, 1);
    RD_REQ = 1'b1;
    @(negedge C);
    RD_REQ = 1'b0;
    check("t4_vld", RD_VLD, 1);
    check("t4_data", RD_DATA, 8'h10);
    check("t4_irq_cap", IRQ, 1);
    @(negedge C);
    check("t4_irq_clr", IRQ, 0);
    EV = 8'h20;
    @(negedge C);
    EV = 8'h00;
    repeat (3) begin
      @(negedge C);
      check("t4_irq_unmasked", IRQ, 0);
    end
    read_hold(1, 8'h00, 8'h00, d, o, p);
    check("t4_data2", d, 8'h20);

`ifdef STICKY_EDGE_EN
    // 5: held input sets once
    EV = 8'h01;
    repeat (10) @(negedge C);
    read_hold(3, 8'h01, 8'h01, d, o, p);
    check("t5_data", d, 8'h01);
    check("t5_ovf", o, 0);
    read_hold(3, 8'h01, 8'h01, d, o, p);
    check("t5_data2", d, 8'h00);
    EV = 8'h00;
    @(negedge C);
`endif

    // 6: reset during RESP
    EV = 8'hFF;
    @(negedge C);
    EV = 8'h00;
    @(negedge C);
    RD_REQ = 1'b1;
    @(posedge C);
    #1;
    check("t6_vld_pre", RD_VLD, 1);
    CLR = 1'b0;
    #1;
    check("t6_vld_async", RD_VLD, 0);
    @(negedge C);
    RD_REQ = 1'b0;
    CLR = 1'b1;
    @(negedge C);
    read_hold(2, 8'h00, 8'h00, d, o, p);
    check("t6_pulses", p, 1);
    check("t6_data", d, 8'h00);

    // Randomized traffic, checked every cycle by the compare process
    for (int i = 0; i < 3000; i++) begin
      @(negedge C);
      EV      = W'($urandom & $urandom & $urandom);
      MASK_WE = ($urandom_range(0, 7) == 0);
      MASK_D  = W'($urandom);
      if ($urandom_range(0, 3) == 0) RD_REQ = ~RD_REQ;
    end
    @(negedge C);
    EV = '0;
    MASK_WE = 1'b0;
    RD_REQ = 1'b0;
    repeat (3) @(negedge C);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/v_status_sticky_reg.md
Name: v_status_sticky_reg

Overview:
- Sticky event-status register with a reader port. Event inputs set status bits with synchronous set; bits stay set until a handshaked read returns them and clears them (clear-on-read).
- Counterpart to the set-priority flip-flop family: it consumes set events and presents them to a reader.
- Sits between event sources (FIFO flags, error strobes) and a control/status readout or interrupt controller.

Parameters:
- WIDTH, 8: number of event/status bits.
- CNT_W, 4: width of the saturating overflow counter.

Ports:
- C  in  1  clock; all state updates on posedge C.
- CLR  in  1  asynchronous active-low reset; all state cleared while low.
- EV  in  WIDTH  event inputs, one per status bit.
- MASK_WE  in  1  interrupt-mask write enable.
- MASK_D  in  WIDTH  mask write data; 1 enables the bit onto IRQ.
- RD_REQ  in  1  read request, level; held until RD_VLD is seen.
- RD_VLD  out  1  one-cycle pulse; RD_DATA and RD_OVF are valid.
- RD_DATA  out  WIDTH  status snapshot returned by the read.
- RD_OVF  out  CNT_W  overflow count snapshot returned by the read.
- IRQ  out  1  registered OR of (STATUS & MASK).

Behaviour:
- Reset (CLR=0, async):
  - STATUS, MASK, OVF_CNT, RD_DATA and RD_OVF are 0.
  - RD_VLD=0, IRQ=0, FSM in IDLE.
- ev_set[i] = EV[i] in level mode; edge-qualified when STICKY_EDGE_EN is defined (see Optional Feature).
- FSM states: IDLE, RESP, HOLD.
  - IDLE -> RESP when RD_REQ=1 at an edge (the capture edge).
  - RESP -> HOLD if RD_REQ=1, else -> IDLE.
  - HOLD -> IDLE when RD_REQ=0.
  - RD_VLD=1 only in RESP, so one held request yields exactly one read. The requester must drop RD_REQ before the next read.
- Capture edge (IDLE with RD_REQ=1):
  - RD_DATA <= STATUS and RD_OVF <= OVF_CNT, taking pre-edge values.
  - STATUS <= ev_set: clear-all, but set has priority, so simultaneous events are not lost.
  - OVF_CNT <= 0.
- Read latency: RD_REQ sampled at edge n; RD_VLD high during cycle n+1. RD_DATA and RD_OVF hold their value until the next capture.
- Non-capture edges:
  - STATUS <= STATUS | ev_set.
  - If any bit has ev_set=1 while already STATUS=1, OVF_CNT increments by 1. This counts cycles, not bits, and saturates at 2^CNT_W-1 with no wrap.
- MASK <= MASK_D on any edge with MASK_WE=1, independent of reads.
- IRQ <= |(STATUS & MASK) using pre-edge values, so IRQ lags STATUS by one cycle.
  - IRQ falls one cycle after a clearing read.
  - IRQ falls one cycle after a mask write that removes the last set bit.
- Reset mid-read (CLR low in RESP or HOLD): immediate return to IDLE; RD_VLD drops asynchronously.

Optional Feature:
- Macro STICKY_EDGE_EN.
- Defined:
  - Adds an EV_q register (reset 0).
  - ev_set = EV & ~EV_q, so only rising edges set bits.
  - An input held high sets once, and counts once toward overflow.
  - EV already high when CLR releases counts as one edge.
- Undefined: ev_set = EV (level). An input held high re-sets the bit every cycle and increments OVF_CNT every cycle after the first.

Decomposition:
- Shared package holds:
  - FSM state encoding constants: IDLE=2'd0, RESP=2'd1, HOLD=2'd2.
  - Default WIDTH and CNT_W constants.
- One sub-module: v_sat_counter, a CNT_W-bit saturating counter with synchronous clear and increment enable, async active-low CLR.
- Edge detect and status bits stay inline.

Test Plan:
All scenarios use WIDTH=8, CNT_W=4, level mode unless stated.
1. Reset: CLR=0 with EV=8'hFF -> STATUS=0, RD_VLD=0, IRQ=0. After release, EV=8'h05 for 1 cycle, then RD_REQ held 3 cycles -> exactly one RD_VLD pulse with RD_DATA=8'h05, RD_OVF=0. Next read returns 8'h00.
2. Set beats clear: STATUS=8'h01 and EV=8'h02 on the capture edge -> RD_DATA=8'h01; a following read returns 8'h02.
3. Overflow saturation: EV[3]=1 held 20 cycles, no read -> OVF_CNT=15 (no wrap). Read -> RD_OVF=15, then OVF_CNT=0.
4. IRQ: MASK_D=8'h10 written, EV[4] pulsed at edge k -> STATUS[4]=1 after edge k, IRQ=1 after edge k+1. Read -> IRQ=0 one cycle after capture. EV[5] alone -> IRQ stays 0.
5. STICKY_EDGE_EN defined: EV[0] high 10 cycles -> read gives RD_DATA=8'h01, RD_OVF=0. Second read gives 8'h00 while EV[0] is still high.
6. Reset mid-read: CLR low during RESP -> RD_VLD=0 immediately. After release, status is 0 and FSM accepts a new RD_REQ.
